// File: rtl/mpadder_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mpadder_ctrl                                             |
// | Description : Sequencing controller for the external 1028-bit adder.   |
// |               Runs ADD (1 pass), SUB (2 passes) and, when the macro    |
// |               MPADD_CTRL_MODADD_EN is defined, MODADD (3 passes).      |
// |               SUB and MODADD supply the missing carry-in by adding     |
// |               an extra +1 pass after the inverted operand.             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mpadder_ctrl (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [1026:0] in_a,
  input  logic [1026:0] in_b,
  input  logic [1026:0] in_m,
  output logic          busy,
  output logic          done,
  output logic [1027:0] result,
  output logic          carry,
  output logic [1027:0] add_a,
  output logic [1027:0] add_b,
  input  logic [1028:0] add_sum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Effective operation after folding reserved / disabled opcodes into ADD
  localparam logic [1:0]    c_KIND_ADD = 2'd0;
  localparam logic [1:0]    c_KIND_SUB = 2'd1;
  localparam logic [1:0]    c_KIND_MOD = 2'd2;
  localparam logic [1027:0] c_ONE      = 1028'd1;

  state_t      r_state;
  logic [1:0]  r_pass;
  logic [1:0]  r_kind;
  logic        r_c0;          // carry out of pass 0 (T[1028] for SUB)

  logic [1:0]    w_kind_in;
  logic [1:0]    w_last_pass;
  logic [1027:0] w_next_b;
  logic [1027:0] w_result;
  logic          w_carry;

`ifdef MPADD_CTRL_MODADD_EN
  logic [1027:0] r_m;         // zero-extended modulus
  logic [1027:0] r_s;         // S[1027:0], fallback result when no reduction
  logic          r_c1;        // T[1028] of the reduction pass
`else
  logic w_unused_m;
  assign w_unused_m = ^in_m;
`endif

  // Decode the requested opcode into the operation that will actually run
  always_comb begin
    w_kind_in = c_KIND_ADD;
    if (op == 2'b01) begin
      w_kind_in = c_KIND_SUB;
    end
`ifdef MPADD_CTRL_MODADD_EN
    else if (op == 2'b10) begin
      w_kind_in = c_KIND_MOD;
    end
`endif
  end

  // Index of the final pass for the running operation
  always_comb begin
    w_last_pass = 2'd0;
    if (r_kind == c_KIND_SUB) begin
      w_last_pass = 2'd1;
    end
`ifdef MPADD_CTRL_MODADD_EN
    else if (r_kind == c_KIND_MOD) begin
      w_last_pass = 2'd2;
    end
`endif
  end

  // Second operand of the next pass: ~M for the MODADD reduction, else the +1
  always_comb begin
    w_next_b = c_ONE;
`ifdef MPADD_CTRL_MODADD_EN
    if ((r_kind == c_KIND_MOD) && (r_pass == 2'd0)) begin
      w_next_b = ~r_m;
    end
`endif
  end

  // Final value and carry formed from the last adder output and stored passes
  always_comb begin
    w_result = add_sum[1027:0];
    w_carry  = add_sum[1028];
    if (r_kind == c_KIND_SUB) begin
      w_carry = r_c0 | add_sum[1028];
    end
`ifdef MPADD_CTRL_MODADD_EN
    if (r_kind == c_KIND_MOD) begin
      w_carry  = r_c1 | add_sum[1028];
      w_result = (r_c1 | add_sum[1028]) ? add_sum[1027:0] : r_s;
    end
`endif
  end

  // Sequencer: accept, issue/capture each pass, then pulse done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pass  <= 2'd0;
      r_kind  <= c_KIND_ADD;
      r_c0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
`ifdef MPADD_CTRL_MODADD_EN
      r_m     <= '0;
      r_s     <= '0;
      r_c1    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ISSUE;
            r_pass  <= 2'd0;
            r_kind  <= w_kind_in;
            busy    <= 1'b1;
            // Pass-0 operands are loaded straight from the request
            add_a   <= {1'b0, in_a};
            add_b   <= (w_kind_in == c_KIND_SUB) ? ~{1'b0, in_b} : {1'b0, in_b};
`ifdef MPADD_CTRL_MODADD_EN
            r_m     <= {1'b0, in_m};
`endif
          end
        end
        S_ISSUE: begin
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          if (r_pass == w_last_pass) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            result  <= w_result;
            carry   <= w_carry;
          end else begin
            r_state <= S_ISSUE;
            r_pass  <= r_pass + 2'd1;
            add_a   <= add_sum[1027:0];
            add_b   <= w_next_b;
            if (r_pass == 2'd0) begin
              r_c0 <= add_sum[1028];
            end
`ifdef MPADD_CTRL_MODADD_EN
            if (r_pass == 2'd0) begin
              r_s  <= add_sum[1027:0];
            end else begin
              r_c1 <= add_sum[1028];
            end
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpadder_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mpadder_ctrl                                          |
// | Description : Self-checking bench for mpadder_ctrl with a one-cycle    |
// |               adder model and an arithmetic reference model.           |
// |               Honours MPADD_CTRL_MODADD_EN when deciding expectations. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mpadder_ctrl;

`ifdef MPADD_CTRL_MODADD_EN
  localparam bit c_MOD_EN = 1'b1;
`else
  localparam bit c_MOD_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [1026:0] in_a;
  logic [1026:0] in_b;
  logic [1026:0] in_m;
  logic          busy;
  logic          done;
  logic [1027:0] result;
  logic          carry;
  logic [1027:0] add_a;
  logic [1027:0] add_b;
  logic [1028:0] add_sum;

  int n_tests = 0;
  int n_fail  = 0;

  mpadder_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_m    (in_m),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: registers its operands, sum visible the following cycle
  always @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

  task automatic chk(input string tag, input logic [1028:0] obs, input logic [1028:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed hi=%h lo=%h expected hi=%h lo=%h",
             tag, obs[1028:965], obs[63:0], exp[1028:965], exp[63:0]);
    end
  endtask

  function automatic logic [1026:0] rnd();
    logic [1055:0] v;
    for (int i = 0; i < 33; i++) v[i*32 +: 32] = $urandom;
    return v[1026:0];
  endfunction

  // Reference: plain arithmetic on the operand values
  task automatic model(input logic [1:0] o, input logic [1026:0] a, input logic [1026:0] b,
                       input logic [1026:0] m, output logic [1027:0] r, output logic c,
                       output int lat);
    logic [1028:0] s;
    s = {2'b00, a} + {2'b00, b};
    if (o == 2'b01) begin
      r   = {1'b0, a} - {1'b0, b};
      c   = (a >= b);
      lat = 5;
    end else if ((o == 2'b10) && c_MOD_EN) begin
      c   = (s >= {2'b00, m});
      r   = c ? 1028'(s - {2'b00, m}) : s[1027:0];
      lat = 7;
    end else begin
      r   = s[1027:0];
      c   = s[1028];
      lat = 3;
    end
  endtask

  // One request; inject=1 pulses start during the first CAPT cycle
  task automatic run_op(input string nm, input logic [1:0] o, input logic [1026:0] a,
                        input logic [1026:0] b, input logic [1026:0] m, input bit inject);
    logic [1027:0] er;
    logic          ec;
    int            lat;
    model(o, a, b, m, er, ec, lat);
    @(negedge clk);
    start = 1'b1; op = o; in_a = a; in_b = b; in_m = m;
    @(posedge clk);
    #1;
    start = 1'b0; in_a = rnd(); in_b = rnd(); in_m = rnd(); op = 2'($urandom_range(0, 3));
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk($sformatf("%s add_a c1", nm), {1'b0, add_a}, {2'b00, a});
        chk($sformatf("%s add_b c1", nm), {1'b0, add_b},
            (o == 2'b01) ? {1'b0, ~{1'b0, b}} : {2'b00, b});
      end
      chk($sformatf("%s busy c%0d", nm, n), {1028'd0, busy}, {1028'd0, (n <= lat)});
      chk($sformatf("%s done c%0d", nm, n), {1028'd0, done}, {1028'd0, (n == lat)});
      if (n == lat) begin
        chk($sformatf("%s result", nm), {1'b0, result}, {1'b0, er});
        chk($sformatf("%s carry", nm), {1028'd0, carry}, {1028'd0, ec});
      end
      start = (inject && n == 2);
      op    = 2'b00;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]    o;
    logic [1026:0] a;
    logic [1026:0] b;
    logic [1026:0] m;

    reset = 1'b1; start = 1'b0; op = 2'b00; in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {1028'd0, busy}, '0);
    chk("reset done", {1028'd0, done}, '0);
    chk("reset result", {1'b0, result}, '0);
    chk("reset carry", {1028'd0, carry}, '0);
    chk("reset add_a", {1'b0, add_a}, '0);
    chk("reset add_b", {1'b0, add_b}, '0);
    reset = 1'b0;

    run_op("add5+7", 2'b00, 1027'd5, 1027'd7, 1027'd13, 1'b0);
    chk("add5+7 exact", {1'b0, result}, 1029'd12);
    run_op("addmax+1", 2'b00, {1027{1'b1}}, 1027'd1, 1027'd13, 1'b0);
    chk("addmax+1 exact", {1'b0, result}, 1029'd1 << 1027);
    run_op("sub5-3", 2'b01, 1027'd5, 1027'd3, 1027'd13, 1'b0);
    chk("sub5-3 exact", {1'b0, result}, 1029'd2);
    run_op("sub3-5", 2'b01, 1027'd3, 1027'd5, 1027'd13, 1'b0);
    chk("sub3-5 exact", {1'b0, result}, {1'b0, {1027{1'b1}}, 1'b0});
    run_op("sub7-7", 2'b01, 1027'd7, 1027'd7, 1027'd13, 1'b0);
    run_op("op10 7,9", 2'b10, 1027'd7, 1027'd9, 1027'd13, 1'b0);
    run_op("op10 2,3", 2'b10, 1027'd2, 1027'd3, 1027'd13, 1'b0);
    run_op("op10 6,7", 2'b10, 1027'd6, 1027'd7, 1027'd13, 1'b0);
    if (c_MOD_EN) chk("mod6+7 exact", {1'b0, result}, 1029'd0);
    else          chk("op10 6+7 add", {1'b0, result}, 1029'd13);
    run_op("op11 add", 2'b11, 1027'd100, 1027'd23, 1027'd13, 1'b0);

    // start pulsed in CAPT must not launch a second request
    run_op("sub inject", 2'b01, 1027'd9, 1027'd4, 1027'd13, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("after inject done", {1028'd0, done}, '0);
      chk("after inject busy", {1028'd0, busy}, '0);
    end

    // reset in the CAPT cycle of a SUB discards it
    @(negedge clk);
    start = 1'b1; op = 2'b01; in_a = 1027'd5; in_b = 1027'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst busy", {1028'd0, busy}, '0);
    chk("midrst done", {1028'd0, done}, '0);
    chk("midrst result", {1'b0, result}, '0);
    chk("midrst carry", {1028'd0, carry}, '0);
    chk("midrst add_a", {1'b0, add_a}, '0);
    chk("midrst add_b", {1'b0, add_b}, '0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("postrst done", {1028'd0, done}, '0);
    end
    run_op("add after rst", 2'b00, 1027'd40, 1027'd2, 1027'd13, 1'b0);

    // Randomised requests
    for (int k = 0; k < 24; k++) begin
      o = 2'($urandom_range(0, 3));
      m = rnd() | 1027'd1;
      a = rnd();
      b = ($urandom_range(0, 3) == 0) ? a : rnd();
      if (o == 2'b10) begin
        a = a % m;
        b = b % m;
        if ($urandom_range(0, 3) == 0) b = m - 1027'd1 - a;
      end
      run_op($sformatf("rnd%0d op%0d", k, o), o, a, b, m, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
